riscv_merger: RTL and testbench

- Merges the two streams that riscv_parser splits apart: the data path (normal packets) and the control path (control/response packets, UDP dst port 0xf1f2).
- Produces one AXI-Stream output toward the MAC/TX side.
- Arbitrates per packet with round-robin fairness. Packets are never interleaved.
- Registered output with one-beat buffering; per-source packet counters for debug.

---
 rtl/riscv_merger.sv | 152 +++++++++++++++
 tb/tb_riscv_merger.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_merger.sv
// Merges the data path and control path AXI-Stream flows into one registered output,
// granting whole packets round-robin and counting forwarded packets per source.
module riscv_merger #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic                              c_s_axis_tvalid,
    output logic                              c_s_axis_tready,
    input  logic                              c_s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt
);

    localparam int unsigned DATA_W = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned USER_W = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {IDLE, DATA, CTRL} state_t;
    typedef enum logic {GNT_DATA, GNT_CTRL} grant_t;

    state_t              state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
    logic [USER_W-1:0]   tuser_q, tuser_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;
    logic [CNT_WIDTH-1:0] ctrl_cnt_q, ctrl_cnt_d;

    logic out_ready;
    logic sel_data, sel_ctrl;
    logic acc_data, acc_ctrl;

    // Arbitration, acceptance and output-register next state
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tuser_d      = tuser_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        data_cnt_d   = data_cnt_q;
        ctrl_cnt_d   = ctrl_cnt_q;
        sel_data     = 1'b0;
        sel_ctrl     = 1'b0;
        out_ready    = !tvalid_q || m_axis_tready;

        case (state_q)
            IDLE: begin
                // On a tie the source not served last wins
                if (c_s_axis_tvalid && (!s_axis_tvalid || last_grant_q == GNT_DATA)) begin
                    sel_ctrl = 1'b1;
                end else if (s_axis_tvalid) begin
                    sel_data = 1'b1;
                end
            end
            DATA:    sel_data = 1'b1;
            CTRL:    sel_ctrl = 1'b1;
            default: state_d  = IDLE;
        endcase

        acc_data = sel_data && out_ready && s_axis_tvalid;
        acc_ctrl = sel_ctrl && out_ready && c_s_axis_tvalid;

        if (acc_data) begin
            tdata_d      = s_axis_tdata;
            tkeep_d      = s_axis_tkeep;
            tuser_d      = s_axis_tuser;
            tlast_d      = s_axis_tlast;
            tvalid_d     = 1'b1;
            last_grant_d = GNT_DATA;
            state_d      = s_axis_tlast ? IDLE : DATA;
            if (s_axis_tlast) begin
                data_cnt_d = data_cnt_q + CNT_WIDTH'(1);
            end
        end else if (acc_ctrl) begin
            tdata_d      = c_s_axis_tdata;
            tkeep_d      = c_s_axis_tkeep;
            tuser_d      = c_s_axis_tuser;
            tlast_d      = c_s_axis_tlast;
            tvalid_d     = 1'b1;
            last_grant_d = GNT_CTRL;
            state_d      = c_s_axis_tlast ? IDLE : CTRL;
            if (c_s_axis_tlast) begin
                ctrl_cnt_d = ctrl_cnt_q + CNT_WIDTH'(1);
            end
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DATA;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tuser_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            data_cnt_q   <= '0;
            ctrl_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            data_cnt_q   <= data_cnt_d;
            ctrl_cnt_q   <= ctrl_cnt_d;
        end
    end

    // Ready only reaches the granted source, and never during reset
    assign s_axis_tready   = aresetn && sel_data && out_ready;
    assign c_s_axis_tready = aresetn && sel_ctrl && out_ready;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign data_pkt_cnt  = data_cnt_q;
    assign ctrl_pkt_cnt  = ctrl_cnt_q;

endmodule

// File: tb/tb_riscv_merger.sv
// Directed bench for riscv_merger: queue-fed source drivers, a negedge output monitor
// with protocol watchdogs, and hand-computed expected beat orders and counts.
module tb_riscv_merger;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned UW = 128;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic aresetn = 1'b0;

    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;

    logic [DW-1:0] c_s_axis_tdata = '0;
    logic [KW-1:0] c_s_axis_tkeep = '0;
    logic [UW-1:0] c_s_axis_tuser = '0;
    logic          c_s_axis_tvalid = 1'b0;
    logic          c_s_axis_tready;
    logic          c_s_axis_tlast = 1'b0;

    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [CW-1:0] data_pkt_cnt;
    logic [CW-1:0] ctrl_pkt_cnt;

    riscv_merger #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .CNT_WIDTH           (CW)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .c_s_axis_tdata (c_s_axis_tdata),
        .c_s_axis_tkeep (c_s_axis_tkeep),
        .c_s_axis_tuser (c_s_axis_tuser),
        .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tready(c_s_axis_tready),
        .c_s_axis_tlast (c_s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .data_pkt_cnt   (data_pkt_cnt),
        .ctrl_pkt_cnt   (ctrl_pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        last;
        int          gap;
    } beat_t;

    beat_t       dq[$];
    beat_t       cq[$];
    logic [16:0] got[$];
    int          got_cyc[$];
    logic [16:0] exp_q[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   viol_grant = 0;
    int   viol_bp = 0;
    int   viol_stable = 0;
    int   viol_side = 0;
    logic d_fire = 1'b0;
    logic c_fire = 1'b0;
    logic d_f, c_f;
    logic d_in_pkt = 1'b0;
    logic c_in_pkt = 1'b0;
    logic stall_prev = 1'b0;
    logic [16:0] stall_val = '0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got_v, input logic [DW-1:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic push_d(input logic [15:0] d, input logic last, input int gap);
        dq.push_back('{d: d, last: last, gap: gap});
    endtask

    task automatic push_c(input logic [15:0] d, input logic last, input int gap);
        cq.push_back('{d: d, last: last, gap: gap});
    endtask

    task automatic exp_add(input logic [15:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_len"}, DW'(got.size()), DW'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got.size()) check_eq($sformatf("%s_beat%0d", tag, i), DW'(got[i]), DW'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic check_counts(input string tag, input int d, input int c);
        check_eq({tag, "_data_cnt"}, DW'(data_pkt_cnt), DW'(d));
        check_eq({tag, "_ctrl_cnt"}, DW'(ctrl_pkt_cnt), DW'(c));
    endtask

    task automatic check_monitors(input string tag);
        check_eq({tag, "_grant_viol"},  DW'(viol_grant),  '0);
        check_eq({tag, "_bp_viol"},     DW'(viol_bp),     '0);
        check_eq({tag, "_stable_viol"}, DW'(viol_stable), '0);
        check_eq({tag, "_side_viol"},   DW'(viol_side),   '0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((dq.size() != 0 || cq.size() != 0 || m_axis_tvalid) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq({tag, "_drain"}, DW'(n < 300), DW'(1));
    endtask

    // Source drivers: present queue heads after each edge, honouring per-beat valid gaps
    always @(posedge clk) begin
        #1;
        if (!aresetn) begin
            dq.delete();
            cq.delete();
        end else begin
            if (d_fire && dq.size() != 0) void'(dq.pop_front());
            if (c_fire && cq.size() != 0) void'(cq.pop_front());
        end
        if (dq.size() != 0 && dq[0].gap > 0) begin
            dq[0].gap = dq[0].gap - 1;
            s_axis_tvalid = 1'b0;
        end else if (dq.size() != 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DW'(dq[0].d);
            s_axis_tkeep  = KW'(dq[0].d);
            s_axis_tuser  = UW'(~dq[0].d);
            s_axis_tlast  = dq[0].last;
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
        if (cq.size() != 0 && cq[0].gap > 0) begin
            cq[0].gap = cq[0].gap - 1;
            c_s_axis_tvalid = 1'b0;
        end else if (cq.size() != 0) begin
            c_s_axis_tvalid = 1'b1;
            c_s_axis_tdata  = DW'(cq[0].d);
            c_s_axis_tkeep  = KW'(cq[0].d);
            c_s_axis_tuser  = UW'(~cq[0].d);
            c_s_axis_tlast  = cq[0].last;
        end else begin
            c_s_axis_tvalid = 1'b0;
            c_s_axis_tlast  = 1'b0;
        end
    end

    // Monitor: handshakes, output capture and protocol watchdogs, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!aresetn) begin
            d_in_pkt   = 1'b0;
            c_in_pkt   = 1'b0;
            stall_prev = 1'b0;
            d_fire     = 1'b0;
            c_fire     = 1'b0;
            got.delete();
            got_cyc.delete();
        end else begin
            d_f = s_axis_tvalid && s_axis_tready;
            c_f = c_s_axis_tvalid && c_s_axis_tready;
            if (d_f && c_f) viol_grant++;
            if ((d_in_pkt || d_f) && c_s_axis_tready) viol_grant++;
            if ((c_in_pkt || c_f) && s_axis_tready) viol_grant++;
            if (m_axis_tvalid && !m_axis_tready && (s_axis_tready || c_s_axis_tready)) viol_bp++;
            if (d_f) d_in_pkt = !s_axis_tlast;
            if (c_f) c_in_pkt = !c_s_axis_tlast;
            if (stall_prev && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata[15:0]} != stall_val))
                viol_stable++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_val  = {m_axis_tlast, m_axis_tdata[15:0]};
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back({m_axis_tlast, m_axis_tdata[15:0]});
                got_cyc.push_back(cyc);
                if (m_axis_tkeep != KW'(m_axis_tdata[15:0]) || m_axis_tuser != UW'(~m_axis_tdata[15:0]))
                    viol_side++;
            end
            d_fire = d_f;
            c_fire = c_f;
        end
    end

    initial begin
        int n;
        // Reset values
        #3;
        check_eq("rst_m_valid", DW'(m_axis_tvalid), '0);
        check_eq("rst_m_last",  DW'(m_axis_tlast),  '0);
        check_eq("rst_m_data",  m_axis_tdata,       '0);
        check_eq("rst_m_keep",  DW'(m_axis_tkeep),  '0);
        check_eq("rst_m_user",  DW'(m_axis_tuser),  '0);
        check_eq("rst_s_ready", DW'(s_axis_tready), '0);
        check_eq("rst_c_ready", DW'(c_s_axis_tready), '0);
        check_counts("rst", 0, 0);
        repeat (2) @(posedge clk);
        #2;
        aresetn = 1'b1;

        // Single 3-beat data packet, one-cycle latency
        push_d(16'h0001, 1'b0, 0);
        push_d(16'h0002, 1'b0, 0);
        push_d(16'h0003, 1'b1, 0);
        @(posedge clk); #2;
        check_eq("single_s_ready", DW'(s_axis_tready), DW'(1));
        check_eq("single_pre_valid", DW'(m_axis_tvalid), '0);
        @(posedge clk); #2;
        check_eq("single_lat_valid", DW'(m_axis_tvalid), DW'(1));
        check_eq("single_lat_data", m_axis_tdata, DW'(16'h0001));
        wait_drain("single");
        exp_add(16'h0001, 1'b0); exp_add(16'h0002, 1'b0); exp_add(16'h0003, 1'b1);
        check_stream("single");
        check_counts("single", 1, 0);
        check_monitors("single");

        // Tie after reset: control first, then data with no bubble
        do_reset();
        push_d(16'h0011, 1'b0, 0); push_d(16'h0012, 1'b1, 0);
        push_c(16'h0021, 1'b0, 0); push_c(16'h0022, 1'b1, 0);
        @(posedge clk); #2;
        check_eq("tie_c_ready", DW'(c_s_axis_tready), DW'(1));
        check_eq("tie_s_ready", DW'(s_axis_tready), '0);
        wait_drain("tie");
        exp_add(16'h0021, 1'b0); exp_add(16'h0022, 1'b1);
        exp_add(16'h0011, 1'b0); exp_add(16'h0012, 1'b1);
        check_stream("tie");
        if (got_cyc.size() == 4) check_eq("tie_no_bubble", DW'(got_cyc[3] - got_cyc[0]), DW'(3));
        check_counts("tie", 1, 1);
        check_monitors("tie");

        // Round-robin: four single-beat packets per source, alternating from control
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_c(16'h0031 + 16'(i), 1'b1, 0);
            push_d(16'h0041 + 16'(i), 1'b1, 0);
        end
        wait_drain("rr");
        for (int i = 0; i < 4; i++) begin
            exp_add(16'h0031 + 16'(i), 1'b1);
            exp_add(16'h0041 + 16'(i), 1'b1);
        end
        check_stream("rr");
        if (got_cyc.size() == 8) check_eq("rr_back2back", DW'(got_cyc[7] - got_cyc[0]), DW'(7));
        check_counts("rr", 4, 4);
        check_monitors("rr");

        // Backpressure on beat 2 of a 4-beat data packet
        do_reset();
        for (int i = 0; i < 4; i++) push_d(16'h0051 + 16'(i), 1'(i == 3), 0);
        n = 0;
        while (!(m_axis_tvalid && m_axis_tdata[15:0] == 16'h0052) && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq("bp_reach_beat2", DW'(n < 50), DW'(1));
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check_eq($sformatf("bp_hold_data%0d", i), DW'(m_axis_tdata[15:0]), DW'(16'h0052));
            check_eq($sformatf("bp_hold_valid%0d", i), DW'(m_axis_tvalid), DW'(1));
            check_eq($sformatf("bp_s_ready%0d", i), DW'(s_axis_tready), '0);
        end
        m_axis_tready = 1'b1;
        wait_drain("bp");
        for (int i = 0; i < 4; i++) exp_add(16'h0051 + 16'(i), 1'(i == 3));
        check_stream("bp");
        check_counts("bp", 1, 0);
        check_monitors("bp");

        // Control source bubble while data waits
        do_reset();
        push_c(16'h0061, 1'b0, 0);
        push_c(16'h0062, 1'b0, 2);
        push_c(16'h0063, 1'b1, 0);
        push_d(16'h0071, 1'b1, 0);
        wait_drain("bubble");
        exp_add(16'h0061, 1'b0); exp_add(16'h0062, 1'b0);
        exp_add(16'h0063, 1'b1); exp_add(16'h0071, 1'b1);
        check_stream("bubble");
        check_counts("bubble", 1, 1);
        check_monitors("bubble");

        // Reset in the middle of a data packet
        push_d(16'h0081, 1'b0, 0);
        push_d(16'h0082, 1'b0, 0);
        push_d(16'h0083, 1'b1, 0);
        n = 0;
        while (!(m_axis_tvalid && m_axis_tdata[15:0] == 16'h0082) && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq("mid_reach_beat2", DW'(n < 50), DW'(1));
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_valid", DW'(m_axis_tvalid), '0);
        check_eq("mid_rst_data", m_axis_tdata, '0);
        check_eq("mid_rst_s_ready", DW'(s_axis_tready), '0);
        check_counts("mid_rst", 0, 0);
        repeat (2) @(posedge clk);
        #2;
        aresetn = 1'b1;
        push_d(16'h0091, 1'b0, 0);
        push_d(16'h0092, 1'b1, 0);
        wait_drain("mid");
        exp_add(16'h0091, 1'b0); exp_add(16'h0092, 1'b1);
        check_stream("mid");
        check_counts("mid", 1, 0);
        check_monitors("mid");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
